// File: rtl/bcd_timer_pkg.sv
// Shared types and helpers for the BCD countdown timer.
// Holds the timer state enum, the BCD digit limit and the nibble validity check.
package bcd_timer_pkg;

    localparam logic [3:0] BCD_MAX = 4'd9;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StRun    = 2'd1,
        StPaused = 2'd2,
        StDone   = 2'd3
    } timer_state_e;

    // True when each of the lowest n nibbles of vec is a legal BCD digit (0..9).
    function automatic logic bcd_valid(input logic [31:0] vec, input int unsigned n);
        logic ok;
        ok = 1'b1;
        for (int unsigned i = 0; i < 8; i++) begin
            if (i < n && vec[4*i +: 4] > BCD_MAX) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

endpackage

// File: rtl/bcd_digit_down.sv
// Single BCD digit decrementer with borrow chaining (purely combinational).
// A digit at 0 wraps to 9 and asks the next digit up for a borrow.
module bcd_digit_down
    import bcd_timer_pkg::*;
(
    input  logic [3:0] i_d,
    input  logic       i_borrow_in,
    output logic [3:0] o_q,
    output logic       o_borrow_out
);

    always_comb begin
        o_q          = i_d;
        o_borrow_out = 1'b0;
        if (i_borrow_in) begin
            if (i_d == 4'd0) begin
                o_q          = BCD_MAX;
                o_borrow_out = 1'b1;
            end else begin
                o_q = i_d - 4'd1;
            end
        end
    end

endmodule

// File: rtl/bcd_countdown_timer.sv
// N-digit BCD countdown timer with pause, reload on rising 'active' and an expiry pulse.
// Define COUNTDOWN_WARN_EN to enable the low-count warning output; otherwise o_warn is tied to 0.
module bcd_countdown_timer
    import bcd_timer_pkg::*;
#(
    parameter int unsigned                 NUM_DIGITS  = 2,
    parameter logic [4*NUM_DIGITS-1:0]     START_VALUE = 'h60,
    parameter logic [4*NUM_DIGITS-1:0]     IDLE_VALUE  = 'h79,
    parameter logic [4*NUM_DIGITS-1:0]     WARN_VALUE  = 'h10
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_tick,
    input  logic                    i_active,
    input  logic                    i_pause,
    output logic [4*NUM_DIGITS-1:0] o_digits,
    output logic                    o_running,
    output logic                    o_expired,
    output logic                    o_warn
);

    if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_chk_width
        $error("NUM_DIGITS must be in 1..8");
    end
    if (!bcd_valid(32'(START_VALUE), NUM_DIGITS)) begin : g_chk_start
        $error("START_VALUE contains a nibble above 9");
    end
    if (!bcd_valid(32'(IDLE_VALUE), NUM_DIGITS)) begin : g_chk_idle
        $error("IDLE_VALUE contains a nibble above 9");
    end
    if (!bcd_valid(32'(WARN_VALUE), NUM_DIGITS)) begin : g_chk_warn
        $error("WARN_VALUE contains a nibble above 9");
    end

    timer_state_e            r_state;
    timer_state_e            w_state_next;
    logic [4*NUM_DIGITS-1:0] r_digits;
    logic [4*NUM_DIGITS-1:0] w_digits_next;
    logic [4*NUM_DIGITS-1:0] w_dec_digits;
    logic [NUM_DIGITS:0]     w_borrow;
    logic                    r_active_q;
    logic                    r_running;
    logic                    r_expired;
    logic                    r_warn;
    logic                    w_expired_next;
    logic                    w_warn_next;
    logic                    w_rise;
    logic                    w_dec_en;

    assign w_rise = i_active & ~r_active_q;

    // Strobe reaches digit 0 only when a decrement is actually allowed this cycle.
    assign w_dec_en = (r_state == StRun) & i_active & ~w_rise & ~i_pause & i_tick;
    assign w_borrow[0] = w_dec_en;

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
        bcd_digit_down u_digit (
            .i_d          (r_digits[4*g +: 4]),
            .i_borrow_in  (w_borrow[g]),
            .o_q          (w_dec_digits[4*g +: 4]),
            .o_borrow_out (w_borrow[g+1])
        );
    end

    always_comb begin
        w_state_next   = r_state;
        w_digits_next  = r_digits;
        w_expired_next = 1'b0;
        if (w_rise) begin
            w_digits_next = START_VALUE;
            w_state_next  = (START_VALUE == '0) ? StDone : StRun;
        end else if (!i_active) begin
            w_digits_next = IDLE_VALUE;
            w_state_next  = StIdle;
        end else begin
            case (r_state)
                StRun: begin
                    if (i_pause) begin
                        w_state_next = StPaused;
                    // A borrow out of the top digit means the count was already zero.
                    end else if (w_dec_en && !w_borrow[NUM_DIGITS]) begin
                        w_digits_next = w_dec_digits;
                        if (w_dec_digits == '0) begin
                            w_state_next   = StDone;
                            w_expired_next = 1'b1;
                        end
                    end
                end
                StPaused: begin
                    if (!i_pause) begin
                        w_state_next = StRun;
                    end
                end
                StIdle, StDone: begin
                    w_state_next = r_state;
                end
                default: begin
                    w_state_next = StIdle;
                end
            endcase
        end
    end

`ifdef COUNTDOWN_WARN_EN
    // Magnitude compare a <= b on BCD vectors, most significant digit decides first.
    function automatic logic bcd_le(input logic [4*NUM_DIGITS-1:0] a,
                                    input logic [4*NUM_DIGITS-1:0] b);
        logic le;
        logic decided;
        le      = 1'b1;
        decided = 1'b0;
        for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
            if (!decided && a[4*i +: 4] != b[4*i +: 4]) begin
                le      = a[4*i +: 4] < b[4*i +: 4];
                decided = 1'b1;
            end
        end
        return le;
    endfunction

    assign w_warn_next = ((w_state_next == StRun) || (w_state_next == StPaused))
                         && bcd_le(w_digits_next, WARN_VALUE);
`else
    assign w_warn_next = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= StIdle;
            r_digits   <= IDLE_VALUE;
            r_active_q <= 1'b0;
            r_running  <= 1'b0;
            r_expired  <= 1'b0;
            r_warn     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_digits   <= w_digits_next;
            r_active_q <= i_active;
            r_running  <= (w_state_next == StRun);
            r_expired  <= w_expired_next;
            r_warn     <= w_warn_next;
        end
    end

    assign o_digits  = r_digits;
    assign o_running = r_running;
    assign o_expired = r_expired;
    assign o_warn    = r_warn;

endmodule
